// File: rtl/switch_debounce_pkg.sv
// Shared types and board-level defaults for the switch debouncer.
package switch_debounce_pkg;

  typedef enum logic [1:0] {
    STABLE_LOW  = 2'd0,
    WAIT_HIGH   = 2'd1,
    STABLE_HIGH = 2'd2,
    WAIT_LOW    = 2'd3
  } state_e;

  localparam int CLK_HZ        = 50000000;
  localparam int DEBOUNCE_MS   = 10;
  localparam int LONG_PRESS_MS = 1000;

  // Widened intermediate keeps large clock rates from overflowing before the divide.
  function automatic int ms_to_cycles(input int ms, input int clk_hz);
    longint cyc;
    cyc = longint'(clk_hz) / 64'sd1000 * longint'(ms);
    return int'(cyc);
  endfunction

endpackage

// File: rtl/sync_ff.sv
// N-stage synchroniser for asynchronous board inputs; stage 0 samples the pin.
module sync_ff #(
  parameter int STAGES = 2,
  parameter int WIDTH  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [STAGES-1:0][WIDTH-1:0] sync_q;
  logic [STAGES-1:0][WIDTH-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/switch_debounce.sv
// Switch conditioner: synchroniser, debounce FSM, edge pulses and press toggle.
// Define SWITCH_DEBOUNCE_LONG_PRESS_EN to enable the long_press pulse.
module switch_debounce
  import switch_debounce_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = ms_to_cycles(DEBOUNCE_MS, CLK_HZ),
  parameter int LONG_CYCLES   = ms_to_cycles(LONG_PRESS_MS, CLK_HZ)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic switch_raw,
  output logic switch_level,
  output logic rise_pulse,
  output logic fall_pulse,
  output logic toggle,
  output logic long_press
);

  localparam int CNT_W = $clog2(LONG_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic s;

  sync_ff #(
    .STAGES(SYNC_STAGES),
    .WIDTH (1)
  ) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (switch_raw),
    .q    (s)
  );

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic             toggle_q, toggle_d;

`ifdef SWITCH_DEBOUNCE_LONG_PRESS_EN
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] LONG_SAT  = CNT_W'(LONG_CYCLES);
  logic long_q, long_d;
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rise_d   = 1'b0;
    fall_d   = 1'b0;
    toggle_d = toggle_q;
`ifdef SWITCH_DEBOUNCE_LONG_PRESS_EN
    long_d   = 1'b0;
`endif
    case (state_q)
      STABLE_LOW: begin
        if (s) begin
          state_d = WAIT_HIGH;
          cnt_d   = CNT_ONE;
        end
      end
      WAIT_HIGH: begin
        if (!s) begin
          state_d = STABLE_LOW;
          cnt_d   = '0;
        end else if (cnt_q == STABLE_LAST) begin
          state_d  = STABLE_HIGH;
          cnt_d    = '0;
          rise_d   = 1'b1;
          toggle_d = ~toggle_q;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      STABLE_HIGH: begin
        if (!s) begin
          state_d = WAIT_LOW;
          cnt_d   = CNT_ONE;
        end
`ifdef SWITCH_DEBOUNCE_LONG_PRESS_EN
        // Count parks one past the threshold so each press pulses only once.
        else if (cnt_q == LONG_LAST) begin
          cnt_d  = LONG_SAT;
          long_d = 1'b1;
        end else if (cnt_q < LONG_LAST) begin
          cnt_d = cnt_q + CNT_ONE;
        end
`endif
      end
      WAIT_LOW: begin
        if (s) begin
          state_d = STABLE_HIGH;
          cnt_d   = '0;
        end else if (cnt_q == STABLE_LAST) begin
          state_d = STABLE_LOW;
          cnt_d   = '0;
          fall_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = STABLE_LOW;
        cnt_d   = '0;
      end
    endcase
    level_d = (state_d == STABLE_HIGH) || (state_d == WAIT_LOW);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= STABLE_LOW;
      cnt_q    <= '0;
      level_q  <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      toggle_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      level_q  <= level_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      toggle_q <= toggle_d;
    end
  end

`ifdef SWITCH_DEBOUNCE_LONG_PRESS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      long_q <= 1'b0;
    end else begin
      long_q <= long_d;
    end
  end

  assign long_press = long_q;
`else
  assign long_press = 1'b0;
`endif

  assign switch_level = level_q;
  assign rise_pulse   = rise_q;
  assign fall_pulse   = fall_q;
  assign toggle       = toggle_q;

endmodule

// File: tb/tb_switch_debounce.sv
// Self-checking bench for switch_debounce: directed segment table, reset sequences, random stimulus.
module tb_switch_debounce;

  localparam int SYNC   = 2;
  localparam int STABLE = 8;
  localparam int LONG   = 20;
`ifdef SWITCH_DEBOUNCE_LONG_PRESS_EN
  localparam int LP_EXP = 1;
`else
  localparam int LP_EXP = 0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  logic switch_raw;
  logic switch_level, rise_pulse, fall_pulse, toggle, long_press;

  switch_debounce #(
    .SYNC_STAGES  (SYNC),
    .STABLE_CYCLES(STABLE),
    .LONG_CYCLES  (LONG)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .switch_raw  (switch_raw),
    .switch_level(switch_level),
    .rise_pulse  (rise_pulse),
    .fall_pulse  (fall_pulse),
    .toggle      (toggle),
    .long_press  (long_press)
  );

  always #10 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: raw history, run length of disagreement, high-time age.
  logic [SYNC-1:0] m_hist;
  logic m_lvl, m_rise, m_fall, m_tog, m_long;
  int   m_run, m_age;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_hist = '0;
    m_lvl  = 1'b0;
    m_rise = 1'b0;
    m_fall = 1'b0;
    m_tog  = 1'b0;
    m_long = 1'b0;
    m_run  = 0;
    m_age  = 0;
  endtask

  task automatic model_edge();
    logic s;
    if (!rst_n) begin
      model_reset();
      return;
    end
    s      = m_hist[SYNC-1];
    m_hist = {m_hist[SYNC-2:0], switch_raw};
    m_rise = 1'b0;
    m_fall = 1'b0;
    m_long = 1'b0;
    if (s != m_lvl) begin
      m_run++;
      m_age = 0;
      if (m_run == STABLE) begin
        m_lvl = s;
        m_run = 0;
        if (s) begin
          m_rise = 1'b1;
          m_tog  = ~m_tog;
        end else begin
          m_fall = 1'b1;
        end
      end
    end else begin
      if (m_lvl && m_run == 0 && m_age < LONG) begin
        m_age++;
        if (m_age == LONG && LP_EXP == 1) m_long = 1'b1;
      end
      m_run = 0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("cycle", {27'd0, switch_level, rise_pulse, fall_pulse, toggle, long_press},
          {27'd0, m_lvl, m_rise, m_fall, m_tog, m_long});
  endtask

  typedef struct {
    logic raw;
    int   cycles;
    logic lvl;
    int   rises;
    int   falls;
    logic tog;
    int   longs;
  } vec_t;

  vec_t tbl[21];

  initial begin
    int nr, nf, nl, lat;
    bit found;
    logic r;
    int len;

    tbl[0]  = '{1'b0,  4, 1'b0, 0, 0, 1'b0, 0};
    tbl[1]  = '{1'b1,  7, 1'b0, 0, 0, 1'b0, 0};      // short glitch
    tbl[2]  = '{1'b0, 12, 1'b0, 0, 0, 1'b0, 0};
    tbl[3]  = '{1'b1,  9, 1'b0, 0, 0, 1'b0, 0};      // clean press, one edge short
    tbl[4]  = '{1'b1,  1, 1'b1, 1, 0, 1'b1, 0};
    tbl[5]  = '{1'b1,  5, 1'b1, 0, 0, 1'b1, 0};
    tbl[6]  = '{1'b0,  9, 1'b1, 0, 0, 1'b1, 0};
    tbl[7]  = '{1'b0,  1, 1'b0, 0, 1, 1'b1, 0};
    tbl[8]  = '{1'b1, 10, 1'b1, 1, 0, 1'b0, 0};      // second press
    tbl[9]  = '{1'b0, 10, 1'b0, 0, 1, 1'b0, 0};
    tbl[10] = '{1'b1,  3, 1'b0, 0, 0, 1'b0, 0};      // bounce
    tbl[11] = '{1'b0,  3, 1'b0, 0, 0, 1'b0, 0};
    tbl[12] = '{1'b1,  3, 1'b0, 0, 0, 1'b0, 0};
    tbl[13] = '{1'b0,  3, 1'b0, 0, 0, 1'b0, 0};
    tbl[14] = '{1'b1,  9, 1'b0, 0, 0, 1'b0, 0};
    tbl[15] = '{1'b1,  1, 1'b1, 1, 0, 1'b1, 0};
    tbl[16] = '{1'b1, 29, 1'b1, 0, 0, 1'b1, LP_EXP}; // long hold
    tbl[17] = '{1'b0, 10, 1'b0, 0, 1, 1'b1, 0};
    tbl[18] = '{1'b1, 10, 1'b1, 1, 0, 1'b0, 0};
    tbl[19] = '{1'b1, 14, 1'b1, 0, 0, 1'b0, 0};      // hold below long threshold
    tbl[20] = '{1'b0, 10, 1'b0, 0, 1, 1'b0, 0};

    rst_n      = 1'b0;
    switch_raw = 1'b0;
    model_reset();
    repeat (3) step();
    check("reset_state", {27'd0, switch_level, rise_pulse, fall_pulse, toggle, long_press}, 32'd0);
    rst_n = 1'b1;

    for (int v = 0; v < 21; v++) begin
      switch_raw = tbl[v].raw;
      nr = 0;
      nf = 0;
      nl = 0;
      for (int c = 0; c < tbl[v].cycles; c++) begin
        step();
        nr += int'(rise_pulse);
        nf += int'(fall_pulse);
        nl += int'(long_press);
      end
      check($sformatf("vec%0d_level", v), 32'(switch_level), 32'(tbl[v].lvl));
      check($sformatf("vec%0d_rises", v), nr, tbl[v].rises);
      check($sformatf("vec%0d_falls", v), nf, tbl[v].falls);
      check($sformatf("vec%0d_toggle", v), 32'(toggle), 32'(tbl[v].tog));
      check($sformatf("vec%0d_long", v), nl, tbl[v].longs);
    end

    // Reset five cycles into WAIT_HIGH, switch kept high through release.
    switch_raw = 1'b1;
    repeat (7) step();
    rst_n = 1'b0;
    model_reset();
    #1;
    check("rst_wait_async", {27'd0, switch_level, rise_pulse, fall_pulse, toggle, long_press}, 32'd0);
    repeat (3) step();
    rst_n = 1'b1;
    lat   = 0;
    found = 1'b0;
    for (int i = 1; i <= 20 && !found; i++) begin
      step();
      if (switch_level) begin
        lat   = i;
        found = 1'b1;
        check("rst_rise_pulse", 32'(rise_pulse), 32'd1);
        check("rst_rise_toggle", 32'(toggle), 32'd1);
      end
    end
    check("rst_rise_latency", lat, 10);

    // Reset while level and toggle are high must clear them without a clock edge.
    step();
    rst_n = 1'b0;
    model_reset();
    #1;
    check("rst_high_async", {27'd0, switch_level, rise_pulse, fall_pulse, toggle, long_press}, 32'd0);
    switch_raw = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    repeat (4) step();

    // Random segments, occasionally long enough for a long press.
    r = 1'b0;
    for (int k = 0; k < 300; k++) begin
      r   = ~r;
      len = ($urandom_range(0, 9) == 0) ? int'($urandom_range(18, 35)) : int'($urandom_range(1, 12));
      switch_raw = r;
      repeat (len) step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/switch_debounce.md
Name: switch_debounce

Overview:
Conditions the raw mechanical board switch before it reaches the LED-blink top level, which consumes the debounced level as its `switch` input.
- Synchronises the asynchronous pin into the 50 MHz clock domain.
- Rejects bounce and glitches shorter than a programmable stable window.
- Publishes a clean level, single-cycle rise/fall pulses and a press-toggled latch.

Parameters:
SYNC_STAGES, 2, number of synchroniser flops on switch_raw; legal range 2..4.
STABLE_CYCLES, 500000, cycles the synchronised input must differ from the current level before the level flips; default is 10 ms at 50 MHz; minimum 2.
LONG_CYCLES, 50000000, long-press threshold in cycles (1 s); used only with the optional feature.
CNT_W, $clog2(LONG_CYCLES+1), counter width; derived, not overridden.

Ports:
clk  input  1  50 MHz system clock; all logic on the rising edge.
rst_n  input  1  asynchronous active-low reset.
switch_raw  input  1  unsynchronised switch pin.
switch_level  output  1  debounced level.
rise_pulse  output  1  one-cycle pulse on each debounced 0->1.
fall_pulse  output  1  one-cycle pulse on each debounced 1->0.
toggle  output  1  inverts on every rise_pulse.
long_press  output  1  one-cycle pulse on a long press; held 0 without the optional feature.

Behaviour:
- Reset (rst_n low, asserted asynchronously, released synchronously by the board):
  - synchroniser flops, counter, switch_level, rise_pulse, fall_pulse, toggle and long_press are all 0.
  - FSM is in STABLE_LOW.
- Synchroniser: switch_raw passes through SYNC_STAGES flops; the last stage is `s`. No other logic samples switch_raw.
- FSM states: STABLE_LOW, WAIT_HIGH, STABLE_HIGH, WAIT_LOW. switch_level is 1 in STABLE_HIGH and WAIT_LOW, otherwise 0, and is registered.
- Transitions from the stable states:
  - STABLE_LOW with s=1 -> WAIT_HIGH, counter=1.
  - STABLE_HIGH with s=0 -> WAIT_LOW, counter=1.
- Transitions in WAIT_HIGH:
  - s=0 -> STABLE_LOW, counter=0 (glitch rejected, no pulse).
  - s=1 and counter==STABLE_CYCLES-1 -> STABLE_HIGH, counter=0, rise_pulse=1 next cycle, toggle inverts.
  - otherwise counter increments.
- WAIT_LOW mirrors WAIT_HIGH and produces fall_pulse instead of rise_pulse.
- Latency: switch_level changes exactly SYNC_STAGES+STABLE_CYCLES rising edges after the first edge that samples a stable new switch_raw value. Each pulse is coincident with the switch_level change and lasts exactly one cycle.
- Glitch handling: any excursion shorter than STABLE_CYCLES cycles at `s` produces no output change. Every bounce restarts the window from 1.
- Counter: never wraps in debounce use. Its compare is `==`, and the counter is cleared on every state change.
- Reset mid-wait: the pending transition is abandoned and all outputs return to their reset values.
- Switch held high through reset release: after the normal latency, a rise_pulse is emitted and toggle goes to 1. This is intended.
- rise_pulse and fall_pulse are never both high. Minimum spacing between them is STABLE_CYCLES cycles.

Optional Feature:
SWITCH_DEBOUNCE_LONG_PRESS_EN.
- Defined:
  - A second use of the counter runs in STABLE_HIGH, counting cycles since rise_pulse.
  - When the count reaches LONG_CYCLES-1, long_press pulses for one cycle.
  - The count then saturates, giving one pulse per press; it clears on leaving STABLE_HIGH.
  - A release before the threshold produces no pulse.
- Undefined:
  - long_press is tied to 0 and the long-press counter logic is absent.
  - CNT_W is still derived from LONG_CYCLES; synthesis trims the unused bits.

Decomposition:
- Shared package switch_debounce_pkg:
  - FSM state enum (2-bit).
  - Default constants CLK_HZ=50000000, DEBOUNCE_MS=10 and LONG_PRESS_MS=1000.
  - Helper function converting ms to cycles.
- One sub-module, sync_ff: a parameterised N-stage synchroniser with async active-low reset, reused for other board inputs.

Test Plan:
All scenarios use SYNC_STAGES=2, STABLE_CYCLES=8 and LONG_CYCLES=20.
- Clean press: switch_raw 0->1 held.
  - switch_level rises exactly 10 cycles later.
  - rise_pulse is high for that single cycle and toggle goes to 1.
- Bounce: switch_raw toggles 1,0,1,0 every 3 cycles, then holds 1.
  - No pulse during the bounce.
  - switch_level rises 10 cycles after the final 0->1.
  - Exactly one rise_pulse.
- Short glitch: 1 held for 7 cycles, then 0.
  - switch_level stays 0; no pulses.
  - A 1 held for 8 cycles does produce a rise.
- Release and double press: press, release, press.
  - Pulse sequence is rise, fall, rise, each 10 cycles after its edge.
  - toggle ends at 0.
- Reset mid-wait: rst_n pulsed low 5 cycles into WAIT_HIGH.
  - All outputs are 0 immediately (asynchronous).
  - After release with switch_raw still 1, a rise occurs 10 cycles later.
- Long press (macro on): held 30 cycles past rise gives one long_press pulse, 20 cycles after rise_pulse. Held 15 cycles gives none. With the macro off, long_press stays 0 throughout.
